regfile_wr_arbiter: RTL and testbench

Write-port controller for the 32×32 register file. It shares the file's single write port (r3_addr / r3_din / r3_wr) between two writeback requesters: requester 0 is the ALU and requester 1 is the memory load path. It also owns a clear sequencer that rewrites registers 1..31 to a programmable value. The block sits between the CPU writeback stage and the register file and is the only driver of the write port.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wr_arbiter_rr_arb2.sv | 38 +++
 rtl/regfile_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port controller.
package regfile_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [31:0] CLEAR_VALUE_DEF = 32'h0000_0000;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-request round-robin arbiter. Grants are combinational and never depend
// on the granted requester's own valid, only on the other requester and the pointer.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    input  logic advance,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt0         = enable & (~valid1 | last_grant_q);
        gnt1         = enable & (~valid0 | ~last_grant_q);
        last_grant_d = last_grant_q;
        // Grants are mutually exclusive under contention, so valid1&gnt1
        // identifies which side completed the transfer.
        if (advance) begin
            last_grant_d = valid1 & gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Sole driver of the register-file write port: arbitrates ALU and load
// writebacks and runs a clear sequence over registers 1..NUM_REGS-1.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned        ADDR_W      = regfile_pkg::ADDR_W,
    parameter int unsigned        DATA_W      = regfile_pkg::DATA_W,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = DATA_W'(CLEAR_VALUE_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] r3_addr,
    output logic [DATA_W-1:0] r3_din,
    output logic              r3_wr
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              r3_wr_q, r3_wr_d;
    logic [ADDR_W-1:0] r3_addr_q, r3_addr_d;
    logic [DATA_W-1:0] r3_din_q, r3_din_d;
    logic              clear_busy_q, clear_busy_d;

    logic arb_en;
    logic gnt0, gnt1;
    logic xfer0, xfer1;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .enable  (arb_en),
        .advance (xfer0 | xfer1),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer0      = req0_valid & gnt0;
    assign xfer1      = req1_valid & gnt1;

    // A clear_start in IDLE pre-empts requests by keeping the arbiter disabled.
    assign arb_en = (state_q == IDLE) & ~clear_start;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        r3_wr_d      = 1'b0;
        r3_addr_d    = r3_addr_q;
        r3_din_d     = r3_din_q;
        clear_busy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d      = CLEAR;
                    r3_wr_d      = 1'b1;
                    r3_addr_d    = cnt_q;
                    r3_din_d     = CLEAR_VALUE;
                    clear_busy_d = 1'b1;
                    cnt_d        = cnt_q + FIRST_ADDR;
                end else if (xfer0) begin
                    // Writes to register 0 complete the handshake but never reach the file.
                    if (req0_addr != '0) begin
                        r3_wr_d   = 1'b1;
                        r3_addr_d = req0_addr;
                        r3_din_d  = req0_data;
                    end
                end else if (xfer1) begin
                    if (req1_addr != '0) begin
                        r3_wr_d   = 1'b1;
                        r3_addr_d = req1_addr;
                        r3_din_d  = req1_data;
                    end
                end
            end

            CLEAR: begin
                r3_wr_d      = 1'b1;
                r3_addr_d    = cnt_q;
                r3_din_d     = CLEAR_VALUE;
                clear_busy_d = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = FIRST_ADDR;
                end else begin
                    cnt_d = cnt_q + FIRST_ADDR;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = FIRST_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= FIRST_ADDR;
            r3_wr_q      <= 1'b0;
            r3_addr_q    <= '0;
            r3_din_q     <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            r3_wr_q      <= r3_wr_d;
            r3_addr_q    <= r3_addr_d;
            r3_din_q     <= r3_din_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    assign r3_wr      = r3_wr_q;
    assign r3_addr    = r3_addr_q;
    assign r3_din     = r3_din_q;
    assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: one cycle per call, expected values hand-computed.
module tb_regfile_wr_arbiter;

    localparam logic [31:0] CV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        clear_start, clear_busy;
    logic [4:0]  r3_addr;
    logic [31:0] r3_din;
    logic        r3_wr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .ADDR_W      (5),
        .DATA_W      (32),
        .CLEAR_VALUE (CV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .r3_addr     (r3_addr),
        .r3_din      (r3_din),
        .r3_wr       (r3_wr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check readies before the edge, outputs after it.
    task automatic cyc(input string tag, input logic rs, input logic cs,
                       input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic chk_rdy, input logic er0, input logic er1,
                       input logic ewr, input logic [4:0] ea, input logic [31:0] ed,
                       input logic ebusy);
        @(negedge clk);
        rst = rs; clear_start = cs;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        if (chk_rdy) begin
            check({tag, ".rdy0"}, {31'd0, req0_ready}, {31'd0, er0});
            check({tag, ".rdy1"}, {31'd0, req1_ready}, {31'd0, er1});
        end
        @(posedge clk);
        #1;
        check({tag, ".wr"},   {31'd0, r3_wr},      {31'd0, ewr});
        check({tag, ".addr"}, {27'd0, r3_addr},    {27'd0, ea});
        check({tag, ".din"},  r3_din,              ed);
        check({tag, ".busy"}, {31'd0, clear_busy}, {31'd0, ebusy});
        $display("cycle %s rst=%0b cs=%0b v0=%0b v1=%0b rdy=%0b%0b -> wr=%0b addr=%0d din=%h busy=%0b",
                 tag, rs, cs, v0, v1, req0_ready, req1_ready, r3_wr, r3_addr, r3_din, clear_busy);
    endtask

    initial begin
        rst = 1'b1; clear_start = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        cyc("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
        cyc("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0);

        // Single ALU write right after reset.
        cyc("single0", 0, 0, 1, 5'd5, 32'hA5A5_0001, 0, 0, 0, 1, 1, 0, 1, 5'd5, 32'hA5A5_0001, 0);

        // Load path to r0: handshake completes, no write, pointer moves to req1.
        cyc("zero1", 0, 0, 0, 0, 0, 1, 5'd0, 32'h0000_0099, 1, 0, 1, 0, 5'd5, 32'hA5A5_0001, 0);

        // Tie for four cycles: req0 wins first, then alternate with no bubbles.
        cyc("tie0", 0, 0, 1, 5'd1, 32'h1111_0001, 1, 5'd2, 32'h2222_0002, 1, 1, 0, 1, 5'd1, 32'h1111_0001, 0);
        cyc("tie1", 0, 0, 1, 5'd1, 32'h1111_0001, 1, 5'd2, 32'h2222_0002, 1, 0, 1, 1, 5'd2, 32'h2222_0002, 0);
        cyc("tie2", 0, 0, 1, 5'd1, 32'h1111_0001, 1, 5'd2, 32'h2222_0002, 1, 1, 0, 1, 5'd1, 32'h1111_0001, 0);
        cyc("tie3", 0, 0, 1, 5'd1, 32'h1111_0001, 1, 5'd2, 32'h2222_0002, 1, 0, 1, 1, 5'd2, 32'h2222_0002, 0);

        // Nothing requested: write enable drops, address and data hold.
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5'd2, 32'h2222_0002, 0);

        // Clear wins over a same-cycle request; second pulse at step 5 is ignored.
        cyc("clr_start", 0, 1, 1, 5'd7, 32'h0000_0077, 0, 0, 0, 1, 0, 0, 1, 5'd1, CV, 1);
        for (int k = 1; k <= 30; k++) begin
            cyc($sformatf("clr%0d", k), 0, (k == 5), 1, 5'd7, 32'h0000_0077, 0, 0, 0,
                1, 0, 0, 1, 5'(k + 1), CV, 1);
        end
        cyc("clr_exit", 0, 0, 1, 5'd7, 32'h0000_0077, 0, 0, 0, 1, 1, 0, 1, 5'd7, 32'h0000_0077, 0);
        cyc("post_clr", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5'd7, 32'h0000_0077, 0);

        // Reset in the middle of a clear, once address 10 is on the port.
        cyc("mclr_start", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'd1, CV, 1);
        for (int k = 1; k <= 9; k++) begin
            cyc($sformatf("mclr%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'(k + 1), CV, 1);
        end
        cyc("mclr_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0, 0);

        // Back in IDLE with the pointer reset, then a fresh clear starts at address 1.
        cyc("after_rst", 0, 0, 1, 5'd3, 32'h0000_0033, 0, 0, 0, 1, 1, 0, 1, 5'd3, 32'h0000_0033, 0);
        cyc("reclr0", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'd1, CV, 1);
        cyc("reclr1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'd2, CV, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
